// File: rtl/ysyx_ifu_l1i_pkg.sv
// ysyx_ifu_l1i_pkg
//   Shared definitions for the L1 instruction cache: the controller FSM
//   encoding and a small helper that classifies refill states.
package ysyx_ifu_l1i_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_REFILL_AR = 3'd2,
        S_REFILL_R  = 3'd3,
        S_RESP      = 3'd4
    } l1i_state_e;

    // True while a line refill is in flight on the bus.
    function automatic logic is_refill(input l1i_state_e s);
        return (s == S_REFILL_AR) || (s == S_REFILL_R);
    endfunction

endpackage

// File: rtl/ysyx_l1i_array.sv
// ysyx_l1i_array
//   Direct-mapped storage for the L1 instruction cache: data words, tags and
//   per-set valid bits. Writes are synchronous, reads are combinational.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset (valid bits only)
//     flush           clears every valid bit on the next edge
//     rd_idx, rd_off  read set / word within line
//     rd_valid/tag/data  read results
//     data_we         write wr_data into word [wr_idx][wr_off]
//     tag_we          write wr_tag into set wr_idx and mark it valid
module ysyx_l1i_array
    import ysyx_ifu_l1i_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 24,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 4,
    parameter int BEAT_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [BEAT_W-1:0] rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              data_we,
    input  logic              tag_we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [BEAT_W-1:0] wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag
);

    logic [DATA_W-1:0] data_mem [SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [SETS-1:0]   valid;

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[wr_idx][wr_off] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    // Flush wins over a same-edge line install so the line stays invalid.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx][rd_off];

endmodule

// File: rtl/ysyx_ifu_l1i.sv
// ysyx_ifu_l1i
//   Blocking, direct-mapped L1 instruction cache for the fetch unit. One
//   request is handled at a time; a miss refills the whole line in word
//   order 0..LINE_WORDS-1 with one AR/R exchange per word.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/req_ready/req_pc     fetch request handshake
//     rsp_valid/rsp_ready/rsp_inst/rsp_pc  instruction response handshake
//     flush                    fence.i: invalidate all lines
//     bus_araddr/arvalid/arready     refill read-address channel
//     bus_rdata/bus_rvalid     refill read-data channel
//     perf_hit/perf_miss       wrapping hit/miss counters
module ysyx_ifu_l1i
    import ysyx_ifu_l1i_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_inst,
    output logic [ADDR_W-1:0] rsp_pc,
    input  logic              flush,
    output logic [ADDR_W-1:0] bus_araddr,
    output logic              bus_arvalid,
    input  logic              bus_arready,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rvalid,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int OFF_W   = $clog2(LINE_WORDS * DATA_W / 8);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
    localparam int BEAT_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    l1i_state_e state, state_nxt;

    logic [ADDR_W-1:0] pc_p0;
    logic [DATA_W-1:0] inst_p1;
    logic [BEAT_W-1:0] beat;
    logic              refill_flushed;
    logic [31:0]       hit_cnt, miss_cnt;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [BEAT_W-1:0] req_off;
    logic [ADDR_W-1:0] line_base;

    logic              arr_valid;
    logic [TAG_W-1:0]  arr_tag;
    logic [DATA_W-1:0] arr_data;

    logic hit, rv_fire, last_beat, tag_we;

    assign req_idx   = IDX_W'(pc_p0 >> OFF_W);
    assign req_tag   = pc_p0[ADDR_W-1 -: TAG_W];
    assign req_off   = BEAT_W'((pc_p0 >> BYTE_SH) & WORD_MASK);
    assign line_base = {req_tag, req_idx, {OFF_W{1'b0}}};

    assign hit       = arr_valid && (arr_tag == req_tag);
    assign rv_fire   = (state == S_REFILL_R) && bus_rvalid;
    assign last_beat = (beat == LAST_BEAT);
    // The line is installed only if no flush touched this refill.
    assign tag_we    = rv_fire && last_beat && !refill_flushed && !flush && !rst;

    ysyx_l1i_array #(
        .DATA_W     (DATA_W),
        .TAG_W      (TAG_W),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .BEAT_W     (BEAT_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .rd_idx   (req_idx),
        .rd_off   (req_off),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .data_we  (rv_fire),
        .tag_we   (tag_we),
        .wr_idx   (req_idx),
        .wr_off   (beat),
        .wr_data  (bus_rdata),
        .wr_tag   (req_tag)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (req_valid)   state_nxt = S_LOOKUP;
            S_LOOKUP:    state_nxt = hit ? S_RESP : S_REFILL_AR;
            S_REFILL_AR: if (bus_arready) state_nxt = S_REFILL_R;
            S_REFILL_R:  if (bus_rvalid)  state_nxt = last_beat ? S_RESP : S_REFILL_AR;
            S_RESP:      if (rsp_ready)   state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready   = (state == S_IDLE);
        rsp_valid   = (state == S_RESP);
        bus_arvalid = (state == S_REFILL_AR);
        bus_araddr  = line_base + (ADDR_W'(beat) << BYTE_SH);
    end

    // Request capture (p0) -> lookup/refill -> response word (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0          <= '0;
            inst_p1        <= '0;
            beat           <= '0;
            refill_flushed <= 1'b0;
            hit_cnt        <= '0;
            miss_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) pc_p0 <= req_pc;
                end
                S_LOOKUP: begin
                    if (hit) begin
                        inst_p1 <= arr_data;
                        hit_cnt <= hit_cnt + 32'd1;
                    end else begin
                        miss_cnt       <= miss_cnt + 32'd1;
                        beat           <= '0;
                        refill_flushed <= 1'b0;
                    end
                end
                S_REFILL_R: begin
                    if (bus_rvalid) begin
                        if (beat == req_off) inst_p1 <= bus_rdata;
                        if (!last_beat)      beat    <= beat + BEAT_W'(1);
                    end
                end
                default: ;
            endcase
            if (flush && is_refill(state)) begin
                refill_flushed <= 1'b1;
            end
        end
    end

    assign rsp_inst  = inst_p1;
    assign rsp_pc    = pc_p0;
    assign perf_hit  = hit_cnt;
    assign perf_miss = miss_cnt;

endmodule

// File: tb/tb_ysyx_ifu_l1i.sv
module tb_ysyx_ifu_l1i;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SETS   = 16;
    localparam int LW     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_inst;
    logic [ADDR_W-1:0] rsp_pc;
    logic              flush;
    logic [ADDR_W-1:0] bus_araddr;
    logic              bus_arvalid;
    logic              bus_arready;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid;
    logic [31:0]       perf_hit;
    logic [31:0]       perf_miss;

    always #5 clk = ~clk;

    ysyx_ifu_l1i #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .LINE_WORDS(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_inst(rsp_inst), .rsp_pc(rsp_pc),
        .flush(flush),
        .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .perf_hit(perf_hit), .perf_miss(perf_miss)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Backing memory: word i of the 0x80000000 region holds 0x1000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a - 32'h8000_0000) >> 2) + 32'h1000;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 4) & 32'hF);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'hF;
    endfunction

    // Reference model: which line each set holds, plus counters.
    bit          m_valid [SETS];
    logic [31:0] m_line  [SETS];
    logic [31:0] m_hit, m_miss;

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    endtask

    // Current transaction, shared with the compare process.
    bit          txn_active = 1'b0;
    int          txn_id     = 0;
    bit          exp_hit;
    logic [31:0] exp_pc, exp_inst, exp_base;
    int          acc_cyc;
    int          ar_base    = 0;
    int          ar_total   = 0;
    logic [31:0] last_inst;

    // Bus slave: random arready, 0..2 cycle read latency, and spurious
    // rvalid pulses whenever no read is outstanding.
    initial begin : bus_slave
        bit          pending = 1'b0;
        bit          r_real  = 1'b0;
        bit          ar_hs, r_hs;
        logic [31:0] ar_addr_s, pend_addr;
        int          rdly;
        bus_arready = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = '0;
        pend_addr   = '0;
        rdly        = 0;
        forever begin
            @(negedge clk); #1;
            ar_hs     = bus_arvalid && bus_arready && !rst;
            ar_addr_s = bus_araddr;
            r_hs      = bus_rvalid && r_real && !rst;
            @(posedge clk); #1;
            if (rst) begin
                pending     = 1'b0;
                r_real      = 1'b0;
                bus_rvalid  = 1'b0;
                bus_arready = 1'b0;
            end else begin
                if (r_hs) pending = 1'b0;
                if (ar_hs) begin
                    pending   = 1'b1;
                    pend_addr = ar_addr_s;
                    rdly      = $urandom_range(0, 2);
                    ar_total++;
                end
                bus_arready = 1'($urandom_range(0, 1));
                if (pending) begin
                    if (rdly == 0) begin
                        bus_rvalid = 1'b1;
                        r_real     = 1'b1;
                        bus_rdata  = mem_word(pend_addr);
                    end else begin
                        rdly--;
                        bus_rvalid = 1'b0;
                        r_real     = 1'b0;
                    end
                end else begin
                    r_real     = 1'b0;
                    bus_rvalid = ($urandom_range(0, 3) == 0);
                    bus_rdata  = $urandom;
                end
            end
        end
    end

    // Compare process: checks DUT outputs against the model every cycle.
    initial begin : compare
        int seen_id = -1;
        forever begin
            @(negedge clk); #1;
            if (!rst && txn_active) begin
                if (bus_arvalid) begin
                    if (exp_hit || (ar_total - ar_base) >= LW)
                        chk("bus_arvalid_unexpected", {31'b0, bus_arvalid}, 32'd0);
                    else
                        chk("bus_araddr", bus_araddr, exp_base + 32'(4 * (ar_total - ar_base)));
                end
                if (rsp_valid) begin
                    if (seen_id != txn_id) begin
                        seen_id = txn_id;
                        if (exp_hit) chk("hit_latency", 32'(cyc - acc_cyc), 32'd2);
                        else         chk("refill_beats", 32'(ar_total - ar_base), 32'(LW));
                        chk("perf_hit", perf_hit, m_hit);
                        chk("perf_miss", perf_miss, m_miss);
                    end
                    chk("rsp_pc", rsp_pc, exp_pc);
                    chk("rsp_inst", rsp_inst, exp_inst);
                    chk("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
                end
            end else if (!rst) begin
                chk("idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
                chk("idle_bus_arvalid", {31'b0, bus_arvalid}, 32'd0);
                chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
            end
        end
    end

    // flush_at: 0 = no flush, k>0 = pulse flush once k-1 AR handshakes have
    // completed while the refill is still in progress.
    task automatic fetch(input logic [31:0] pc, input int flush_at, input int hold);
        int  s;
        int  waitc;
        bit  fl_done;
        s       = set_of(pc);
        exp_hit = m_valid[s] && (m_line[s] == line_of(pc));
        if (exp_hit) m_hit = m_hit + 32'd1;
        else         m_miss = m_miss + 32'd1;
        exp_pc   = pc;
        exp_inst = mem_word(pc);
        exp_base = line_of(pc);
        ar_base  = ar_total;
        acc_cyc  = cyc;
        txn_id++;
        txn_active = 1'b1;
        req_valid  = 1'b1;
        req_pc     = pc;
        @(negedge clk);
        req_valid = 1'b0;
        req_pc    = $urandom;
        waitc     = 0;
        fl_done   = 1'b0;
        while (!rsp_valid) begin
            if (flush_at > 0 && !fl_done && (bus_arvalid || ar_total != ar_base)
                && (ar_total - ar_base) >= flush_at - 1) begin
                flush   = 1'b1;
                fl_done = 1'b1;
                model_clear();
            end else begin
                flush = 1'b0;
            end
            @(negedge clk);
            waitc++;
            if (waitc > 400) begin
                chk("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
                finish_tb();
            end
        end
        flush     = 1'b0;
        last_inst = rsp_inst;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (!exp_hit && !fl_done) begin
            m_valid[s] = 1'b1;
            m_line[s]  = line_of(pc);
        end
        txn_active = 1'b0;
    endtask

    task automatic idle_flush();
        flush = 1'b1;
        model_clear();
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        chk("watchdog", 32'd0, 32'd1);
        finish_tb();
    end

    initial begin : main
        int waitc;
        logic [31:0] pc;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_pc    = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        m_hit     = '0;
        m_miss    = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_bus_arvalid", {31'b0, bus_arvalid}, 32'd0);
        chk("rst_perf_hit", perf_hit, 32'd0);
        chk("rst_perf_miss", perf_miss, 32'd0);
        chk("rst_rsp_inst", rsp_inst, 32'd0);
        chk("rst_rsp_pc", rsp_pc, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss, then hit in the same line.
        fetch(32'h8000_0004, 0, 0);
        chk("cold_inst", last_inst, 32'h0000_1001);
        chk("cold_perf_miss", perf_miss, 32'd1);
        chk("cold_beats", 32'(ar_total - ar_base), 32'd4);
        fetch(32'h8000_000C, 0, 0);
        chk("warm_inst", last_inst, 32'h0000_1003);
        chk("warm_perf_hit", perf_hit, 32'd1);
        chk("warm_beats", 32'(ar_total - ar_base), 32'd0);

        // Conflict eviction on set 0.
        fetch(32'h8000_0104, 0, 0);
        chk("conflict_inst", last_inst, 32'h0000_1041);
        fetch(32'h8000_0004, 0, 0);
        chk("evicted_perf_miss", perf_miss, 32'd3);

        // Flush during refill: response delivered, line not installed.
        fetch(32'h8000_0100, 0, 0);
        fetch(32'h8000_0000, 3, 0);
        chk("flushed_inst", last_inst, 32'h0000_1000);
        fetch(32'h8000_0000, 0, 0);
        chk("after_flush_perf_miss", perf_miss, 32'd6);

        // Consumer stall while a hit is held.
        fetch(32'h8000_0008, 0, 5);
        chk("stall_inst", last_inst, 32'h0000_1002);
        chk("stall_perf_hit", perf_hit, 32'd2);

        // Reset while a refill address is pending.
        exp_hit  = 1'b0;
        exp_pc   = 32'h8000_0300;
        exp_inst = mem_word(32'h8000_0300);
        exp_base = 32'h8000_0300;
        ar_base  = ar_total;
        m_miss   = m_miss + 32'd1;
        txn_id++;
        txn_active = 1'b1;
        req_valid  = 1'b1;
        req_pc     = 32'h8000_0300;
        @(negedge clk);
        req_valid = 1'b0;
        waitc = 0;
        while (!bus_arvalid && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("rst_mid_arvalid_seen", {31'b0, bus_arvalid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_arvalid", {31'b0, bus_arvalid}, 32'd0);
        chk("rst_mid_perf_hit", perf_hit, 32'd0);
        chk("rst_mid_perf_miss", perf_miss, 32'd0);
        chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        rst        = 1'b0;
        txn_active = 1'b0;
        m_hit      = '0;
        m_miss     = '0;
        model_clear();
        @(negedge clk);
        fetch(32'h8000_0300, 0, 0);
        chk("post_rst_perf_miss", perf_miss, 32'd1);

        // Randomized traffic over 8 tags per set, with flushes and stalls.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 11) == 0) idle_flush();
            pc = 32'h8000_0000 + (32'($urandom_range(0, 511)) << 2);
            fetch(pc, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0,
                  int'($urandom_range(0, 3)));
        end
        chk("final_perf_hit", perf_hit, m_hit);
        chk("final_perf_miss", perf_miss, m_miss);
        finish_tb();
    end

endmodule
